data_modulate_kxk: RTL and testbench

DATA_MODULATE_KXK -- requirements
Module: data_modulate_kxk

---
 rtl/data_modulate_pkg.sv | 18 +
 rtl/data_modulate_kxk_if.sv | 32 +++
 rtl/data_modulate_kxk_controller.sv | 88 ++++++++
 rtl/data_modulate_kxk.sv | 87 ++++++++
 tb/tb_data_modulate_kxk.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_modulate_pkg.sv
// Shared definitions for the KxK sliding-window modulator: controller state
// encoding and the legality rule for the window side length.
package data_modulate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int K_MIN = 3;
  localparam int K_MAX = 9;

  function automatic bit k_is_legal(input int k);
    return (k >= K_MIN) && (k <= K_MAX) && ((k % 2) == 1);
  endfunction

endpackage

// File: rtl/data_modulate_kxk_if.sv
// Column-in / window-out bus of the KxK window modulator, plus frame control
// and the controller state for observation.
interface data_modulate_kxk_if #(
  parameter int K      = 7,
  parameter int DATA_W = 8
) ();
  import data_modulate_pkg::*;

  // Both channels: a transfer happens on a rising clock edge where valid and
  // ready are high together; the sender holds valid and data stable until then.
  logic                     start_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [K*DATA_W-1:0]      col_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [K*K*DATA_W-1:0]    window_o;
  logic                     busy_o;
  logic                     done_o;
  state_t                   dbg_state;

  modport master (
    output start_i, valid_i, col_i, ready_i,
    input  ready_o, valid_o, window_o, busy_o, done_o, dbg_state
  );

  modport slave (
    input  start_i, valid_i, col_i, ready_i,
    output ready_o, valid_o, window_o, busy_o, done_o, dbg_state
  );

endinterface

// File: rtl/data_modulate_kxk_controller.sv
// Frame controller: IDLE/RUN/DONE sequencing plus the column and row-group
// counters that decide which accepted beats complete a window.
module data_modulate_kxk_controller
  import data_modulate_pkg::*;
#(
  parameter int K    = 7,
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   start,
  input  logic   beat_acc,
  input  logic   win_hs,
  output state_t state,
  output logic   busy,
  output logic   done,
  output logic   qualify
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS - K + 2);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - K);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          last_pend;

  // A beat completes a window only once the current row has K columns in it.
  assign qualify = (col_cnt >= COL_FIRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      last_pend <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          col_cnt   <= '0;
          row_cnt   <= '0;
          last_pend <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (beat_acc) begin
            if (col_cnt == COL_LAST) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
              if (row_cnt == ROW_LAST) last_pend <= 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
          // last_pend is registered, so a handshake in the same cycle as the
          // final beat belongs to the previous window and does not end the frame.
          if (win_hs && last_pend) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          done      <= 1'b0;
          col_cnt   <= '0;
          row_cnt   <= '0;
          last_pend <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_modulate_kxk.sv
// KxK sliding-window former: shifts in one K-pixel column per accepted beat
// and presents each complete KxK window with a valid/ready handshake.
module data_modulate_kxk
  import data_modulate_pkg::*;
#(
  parameter int K      = 7,
  parameter int DATA_W = 8,
  parameter int COLS   = 640,
  parameter int ROWS   = 480
) (
  input  logic                clk,
  input  logic                rst_n,
  data_modulate_kxk_if.slave  bus
);

  if (!k_is_legal(K)) begin : g_bad_k
    $fatal(1, "data_modulate_kxk: K must be odd and within 3..9");
  end
  if (COLS < K) begin : g_bad_cols
    $fatal(1, "data_modulate_kxk: COLS must be >= K");
  end
  if (ROWS < K) begin : g_bad_rows
    $fatal(1, "data_modulate_kxk: ROWS must be >= K");
  end

  logic [K*K*DATA_W-1:0] window_q;
  logic                  valid_q;
  logic                  ready;
  logic                  beat_acc;
  logic                  win_hs;
  logic                  busy;
  logic                  done;
  logic                  qualify;
  state_t                state;

  // A held window blocks intake so it cannot be overwritten before it is taken.
  assign ready    = busy && (!valid_q || bus.ready_i);
  assign beat_acc = bus.valid_i && ready;
  assign win_hs   = valid_q && bus.ready_i;

  data_modulate_kxk_controller #(
    .K    (K),
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus.start_i),
    .beat_acc (beat_acc),
    .win_hs   (win_hs),
    .state    (state),
    .busy     (busy),
    .done     (done),
    .qualify  (qualify)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_q <= '0;
    end else if (beat_acc) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          window_q[(r*K + c)*DATA_W +: DATA_W] <= window_q[(r*K + c + 1)*DATA_W +: DATA_W];
        end
        window_q[(r*K + K - 1)*DATA_W +: DATA_W] <= bus.col_i[r*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (beat_acc && qualify) begin
      valid_q <= 1'b1;
    end else if (win_hs) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.window_o  = window_q;
  assign bus.busy_o    = busy;
  assign bus.done_o    = done;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_data_modulate_kxk.sv
// Directed bench for data_modulate_kxk: fill/latency, backpressure, row wrap,
// ignore rules, reset abort and a K sweep, checked with immediate assertions.
module tb_data_modulate_kxk;
  import data_modulate_pkg::*;

  localparam int N  = 4;
  localparam int WW = 392;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start  [N];
  logic          valid  [N];
  logic          rdy_in [N];
  logic [55:0]   col    [N];
  wire           rdy_out[N];
  wire           vout   [N];
  wire           busy   [N];
  wire           done   [N];
  wire  [WW-1:0] win    [N];
  wire  [1:0]    dbg    [N];

  int kk  [N] = '{3, 3, 5, 7};
  int ncol[N] = '{5, 5, 7, 9};
  int nrow[N] = '{5, 4, 6, 8};

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int KP = (g < 2) ? 3 : (g == 2) ? 5 : 7;
    localparam int CP = KP + 2;
    localparam int RP = (g == 0) ? 5 : KP + 1;

    data_modulate_kxk_if #(.K(KP), .DATA_W(8)) ifc ();

    assign ifc.start_i = start[g];
    assign ifc.valid_i = valid[g];
    assign ifc.ready_i = rdy_in[g];
    assign ifc.col_i   = col[g][KP*8-1:0];
    assign rdy_out[g]  = ifc.ready_o;
    assign vout[g]     = ifc.valid_o;
    assign busy[g]     = ifc.busy_o;
    assign done[g]     = ifc.done_o;
    assign win[g]      = WW'(ifc.window_o);
    assign dbg[g]      = ifc.dbg_state;

    data_modulate_kxk #(.K(KP), .DATA_W(8), .COLS(CP), .ROWS(RP)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
    );
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sel      = 0;
  int done_cnt = 0;
  int hs_cyc   = 0;
  int done_cyc = 0;
  logic [WW-1:0] got_q[$];
  logic [WW-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vout[sel] && rdy_in[sel]) begin
      got_q.push_back(win[sel]);
      hs_cyc <= cyc;
    end
    if (done[sel]) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_w(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_v(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((r << 4) + c);
  endfunction

  function automatic logic [WW-1:0] exp_win(input int k, input int rg, input int ce);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        w[(r*k + c)*8 +: 8] = pix(rg + r, ce - k + 1 + c);
    return w;
  endfunction

  task automatic set_col(input int d, input int b);
    int rg;
    int cc;
    rg = b / ncol[d];
    cc = b % ncol[d];
    col[d] = '0;
    for (int k = 0; k < kk[d]; k++) col[d][k*8 +: 8] = pix(rg + k, cc);
  endtask

  task automatic send_beat(input int d, input int b);
    int  n;
    logic acc;
    set_col(d, b);
    valid[d] = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = rdy_out[d];
      @(posedge clk);
      #1;
      n++;
    end
    valid[d] = 1'b0;
    if (!acc) check_v($sformatf("beat_accept_timeout_%0d", b), 32'(acc), 32'd1);
  endtask

  task automatic send_range(input int d, input int b0, input int b1);
    for (int b = b0; b <= b1; b++) send_beat(d, b);
  endtask

  task automatic start_frame(input int d);
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    check_v("enter_run", 32'(dbg[d]), 32'(ST_RUN));
  endtask

  task automatic finish_frame(input int d, input int base, input int dbase, input string tag);
    int n;
    int nexp;
    n = 0;
    while (!done[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_v({tag, "_done_seen"}, 32'(done[d]), 32'd1);
    // start during the DONE cycle must be ignored
    start[d] = 1'b1;
    @(posedge clk);
    #1;
    start[d] = 1'b0;
    @(negedge clk);
    check_v({tag, "_back_idle"}, 32'(dbg[d]), 32'(ST_IDLE));
    check_v({tag, "_done_one_cycle"}, 32'(done[d]), 32'd0);
    repeat (2) @(negedge clk);
    check_v({tag, "_done_pulses"}, 32'(done_cnt - dbase), 32'd1);
    check_v({tag, "_done_after_last_hs"}, 32'(done_cyc - hs_cyc), 32'd1);
    nexp = (nrow[d] - kk[d] + 1) * (ncol[d] - kk[d] + 1);
    check_v({tag, "_win_count"}, 32'(got_q.size() - base), 32'(nexp));
    exp_q.delete();
    for (int rg = 0; rg <= nrow[d] - kk[d]; rg++)
      for (int ce = kk[d] - 1; ce < ncol[d]; ce++)
        exp_q.push_back(exp_win(kk[d], rg, ce));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size())
        check_w($sformatf("%s_win%0d", tag, i), got_q[base + i], exp_q[i]);
  endtask

  initial begin
    logic [WW-1:0] w1;
    logic [WW-1:0] w4;
    logic [WW-1:0] held;
    logic [7:0]    w1_b [9];
    logic [7:0]    w4_b [9];
    int base;
    int dbase;

    w1_b = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    w4_b = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
    w1 = '0;
    w4 = '0;
    for (int i = 0; i < 9; i++) begin
      w1[i*8 +: 8] = w1_b[i];
      w4[i*8 +: 8] = w4_b[i];
    end

    // clock/reset
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      start[i]  = 1'b0;
      valid[i]  = 1'b0;
      rdy_in[i] = 1'b1;
      col[i]    = '0;
    end
    repeat (2) @(negedge clk);
    check_v("reset_state", 32'(dbg[0]), 32'(ST_IDLE));
    check_v("reset_valid", 32'(vout[0]), 32'd0);
    check_v("reset_ready", 32'(rdy_out[0]), 32'd0);
    check_v("reset_busy", 32'(busy[0]), 32'd0);
    check_v("reset_done", 32'(done[0]), 32'd0);
    check_w("reset_window", win[0], '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // frame 1: fill, latency, row wrap
    sel   = 0;
    base  = got_q.size();
    dbase = done_cnt;
    start_frame(0);
    check_v("busy_in_run", 32'(busy[0]), 32'd1);
    send_range(0, 0, 1);
    check_v("fill_no_valid", 32'(vout[0]), 32'd0);
    send_beat(0, 2);
    check_v("first_valid_latency", 32'(vout[0]), 32'd1);
    check_w("first_window", win[0], w1);
    send_range(0, 3, 14);
    finish_frame(0, base, dbase, "f1");
    if (got_q.size() > base + 3) check_w("row_wrap_win4", got_q[base + 3], w4);
    else check_v("row_wrap_win4_present", 32'(got_q.size() - base), 32'd4);

    // frame 2: backpressure
    base  = got_q.size();
    dbase = done_cnt;
    start_frame(0);
    send_range(0, 0, 3);
    rdy_in[0] = 1'b0;
    held = win[0];
    check_w("bp_held_is_win2", held, exp_win(3, 0, 3));
    set_col(0, 4);
    valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_v($sformatf("bp_ready_low_%0d", i), 32'(rdy_out[0]), 32'd0);
      check_v($sformatf("bp_valid_high_%0d", i), 32'(vout[0]), 32'd1);
      check_w($sformatf("bp_window_stable_%0d", i), win[0], held);
      @(posedge clk);
      #1;
    end
    rdy_in[0] = 1'b1;
    send_range(0, 4, 14);
    finish_frame(0, base, dbase, "f2");

    // frame 3: beats in IDLE and start mid-frame are ignored
    base  = got_q.size();
    dbase = done_cnt;
    set_col(0, 9);
    valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_v($sformatf("idle_ready_low_%0d", i), 32'(rdy_out[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    valid[0] = 1'b0;
    check_v("idle_stays_idle", 32'(dbg[0]), 32'(ST_IDLE));
    start_frame(0);
    send_range(0, 0, 6);
    start[0] = 1'b1;
    send_beat(0, 7);
    start[0] = 1'b0;
    check_v("mid_start_still_run", 32'(dbg[0]), 32'(ST_RUN));
    send_range(0, 8, 14);
    finish_frame(0, base, dbase, "f3");

    // frame 4: reset abort after 7 beats
    start_frame(0);
    send_range(0, 0, 6);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_v($sformatf("abort_state_%0d", i), 32'(dbg[0]), 32'(ST_IDLE));
      check_v($sformatf("abort_valid_%0d", i), 32'(vout[0]), 32'd0);
      check_v($sformatf("abort_ready_%0d", i), 32'(rdy_out[0]), 32'd0);
      check_v($sformatf("abort_busy_%0d", i), 32'(busy[0]), 32'd0);
      check_v($sformatf("abort_done_%0d", i), 32'(done[0]), 32'd0);
      check_w($sformatf("abort_window_%0d", i), win[0], '0);
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    base  = got_q.size();
    dbase = done_cnt;
    repeat (6) @(negedge clk);
    check_v("abort_no_windows", 32'(got_q.size() - base), 32'd0);
    check_v("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    @(posedge clk);
    #1;

    // frame 5: clean frame after abort
    base  = got_q.size();
    dbase = done_cnt;
    start_frame(0);
    send_range(0, 0, 14);
    finish_frame(0, base, dbase, "f5");

    // K sweep: K in {3,5,7}, COLS=K+2, ROWS=K+1
    for (int d = 1; d < N; d++) begin
      @(posedge clk);
      #1;
      sel   = d;
      base  = got_q.size();
      dbase = done_cnt;
      start_frame(d);
      send_range(d, 0, (nrow[d] - kk[d] + 1) * ncol[d] - 1);
      finish_frame(d, base, dbase, $sformatf("sweep_k%0d", kk[d]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
